// File: rtl/id_ctrl_pkg.sv
// Shared definitions for the RV32I decode/buffer slice: opcodes, control bundle
// layout and the field encodings used by the EX stage.
package id_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_CSR = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [1:0] result_src;
        logic       mem_write;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic       reg_write;
    } ctrl_t;

    function automatic ctrl_t make_ctrl(
        input logic       br,
        input logic       jal,
        input logic       jalr,
        input logic [1:0] res,
        input logic       mw,
        input logic [1:0] srca,
        input logic       srcb,
        input logic [2:0] imm,
        input logic [1:0] aluop,
        input logic       rw
    );
        ctrl_t c;
        c.branch     = br;
        c.jal        = jal;
        c.jalr       = jalr;
        c.result_src = res;
        c.mem_write  = mw;
        c.alu_src_a  = srca;
        c.alu_src_b  = srcb;
        c.imm_src    = imm;
        c.alu_op     = aluop;
        c.reg_write  = rw;
        return c;
    endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Combinational RV32I main decoder: instruction -> {ctrl, illegal, csr}.
// CSR opcode decode is enabled by the ZICSR_DECODE_EN macro.
module id_decode_comb
    import id_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_illegal,
    output logic        o_csr
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_unused;
    ctrl_t      w_ctrl;
    logic       w_illegal;
    logic       w_csr;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_unused = ^i_instr[31:15];

    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        w_csr     = 1'b0;
        if (i_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OP_LOAD:   w_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, RES_MEM, 1'b0, SRCA_RS1, 1'b1, IMM_I, ALUOP_ADD, 1'b1);
                OP_STORE:  w_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, RES_ALU, 1'b1, SRCA_RS1, 1'b1, IMM_S, ALUOP_ADD, 1'b0);
                OP_RTYPE:  w_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, RES_ALU, 1'b0, SRCA_RS1, 1'b0, IMM_I, ALUOP_R, 1'b1);
                OP_BRANCH: w_ctrl = make_ctrl(1'b1, 1'b0, 1'b0, RES_ALU, 1'b0, SRCA_RS1, 1'b0, IMM_B, ALUOP_BR, 1'b0);
                OP_IALU:   w_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, RES_ALU, 1'b0, SRCA_RS1, 1'b1, IMM_I, ALUOP_I, 1'b1);
                OP_JAL:    w_ctrl = make_ctrl(1'b0, 1'b1, 1'b0, RES_PC4, 1'b0, SRCA_ZERO, 1'b0, IMM_J, ALUOP_ADD, 1'b1);
                OP_JALR: begin
                    if (w_funct3 == 3'b000)
                        w_ctrl = make_ctrl(1'b0, 1'b0, 1'b1, RES_PC4, 1'b0, SRCA_RS1, 1'b1, IMM_I, ALUOP_ADD, 1'b1);
                    else
                        w_illegal = 1'b1;
                end
                OP_LUI:    w_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, RES_ALU, 1'b0, SRCA_ZERO, 1'b1, IMM_U, ALUOP_ADD, 1'b1);
                OP_AUIPC:  w_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, RES_ALU, 1'b0, SRCA_PC, 1'b1, IMM_U, ALUOP_ADD, 1'b1);
`ifdef ZICSR_DECODE_EN
                OP_SYSTEM: begin
                    // ECALL/EBREAK are legal but carry no control and are not CSR ops
                    if (w_funct3 != 3'b000) begin
                        w_ctrl = make_ctrl(1'b0, 1'b0, 1'b0, RES_ALU, 1'b0, SRCA_RS1, 1'b1, IMM_CSR, ALUOP_ADD, 1'b1);
                        w_csr  = 1'b1;
                    end
                end
`endif
                default:   w_illegal = 1'b1;
            endcase
        end
        if (i_instr[11:7] == 5'd0)
            w_ctrl.reg_write = 1'b0;
    end

    assign o_ctrl    = w_ctrl;
    assign o_illegal = w_illegal;
    assign o_csr     = w_csr;

endmodule

// File: rtl/id_ctrl_pipe.sv
// Decode stage with a BUF_DEPTH-entry valid/ready FIFO, flush and a saturating
// illegal-instruction counter. ZICSR_DECODE_EN enables CSR decode (out_csr).
module id_ctrl_pipe
    import id_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      out_ctrl,
    output logic             out_illegal,
    output logic             out_csr,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    ctrl_t            w_ctrl;
    logic             w_illegal;
    logic             w_csr;
    logic             w_push;
    logic             w_pop;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_illegal_cnt;

    ctrl_t            r_mem_ctrl  [BUF_DEPTH];
    logic             r_mem_ill   [BUF_DEPTH];
    logic             r_mem_csr   [BUF_DEPTH];
    logic [31:0]      r_mem_instr [BUF_DEPTH];
    logic [XLEN-1:0]  r_mem_pc    [BUF_DEPTH];

    id_decode_comb u_decode (
        .i_instr   (in_instr),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_illegal),
        .o_csr     (w_csr)
    );

    // Ready depends only on occupancy, so EX backpressure never reaches IF combinationally
    assign in_ready  = (r_count < DEPTH_C);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem_ctrl[i]  <= '0;
                r_mem_ill[i]   <= 1'b0;
                r_mem_csr[i]   <= 1'b0;
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_ctrl[r_wr_ptr]  <= w_ctrl;
                r_mem_ill[r_wr_ptr]   <= w_illegal;
                r_mem_csr[r_wr_ptr]   <= w_csr;
                r_mem_instr[r_wr_ptr] <= in_instr;
                r_mem_pc[r_wr_ptr]    <= in_pc;
                r_wr_ptr              <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_illegal_cnt <= '0;
        else if (w_push && w_illegal && (r_illegal_cnt != '1))
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end

    assign out_ctrl    = r_mem_ctrl[r_rd_ptr];
    assign out_illegal = r_mem_ill[r_rd_ptr];
    assign out_csr     = r_mem_csr[r_rd_ptr];
    assign out_instr   = r_mem_instr[r_rd_ptr];
    assign out_pc      = r_mem_pc[r_rd_ptr];
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe with a queue scoreboard of expected head entries.
module tb_id_ctrl_pipe;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = '0;
    logic [31:0]      in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [14:0]      out_ctrl;
    logic             out_illegal;
    logic             out_csr;
    logic [31:0]      out_instr;
    logic [31:0]      out_pc;
    logic [CNT_W-1:0] illegal_cnt;

    typedef struct packed {
        logic [14:0] ctrl;
        logic        ill;
        logic        csr;
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t             q[$];
    exp_t             cur;
    int               total = 0;
    int               bad = 0;
    int               n;
    logic [CNT_W-1:0] exp_cnt = '0;

    id_ctrl_pipe #(.XLEN(32), .BUF_DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_illegal (out_illegal),
        .out_csr     (out_csr),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: handshakes are evaluated mid-cycle, ahead of the edge that performs them
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pop", 64'(out_instr), 64'hDEAD);
                    end else begin
                        e = q.pop_front();
                        chk("ctrl", 64'(out_ctrl), 64'(e.ctrl));
                        chk("illegal", 64'(out_illegal), 64'(e.ill));
                        chk("csr", 64'(out_csr), 64'(e.csr));
                        chk("instr", 64'(out_instr), 64'(e.instr));
                        chk("pc", 64'(out_pc), 64'(e.pc));
                    end
                end
                if (in_valid && in_ready)
                    q.push_back(cur);
            end
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [14:0] c, input logic il, input logic cs);
        in_instr = instr;
        in_pc    = pc;
        cur      = '{c, il, cs, instr, pc};
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(output int cycles);
        logic ok;
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        if (ok && cur.ill && exp_cnt != '1)
            exp_cnt = exp_cnt + 1'b1;
        chk("accept", 64'(ok), 64'd1);
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [14:0] c, input logic il, input logic cs);
        int k;
        drive(instr, pc, c, il, cs);
        wait_accept(k);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        chk("rst_csr", 64'(out_csr), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_cnt", 64'(illegal_cnt), 64'd0);
        rst_n = 1'b1;

        drive(32'h00012083, 32'h100, 15'b000_01_0_00_1_000_00_1, 1'b0, 1'b0);
        wait_accept(n);
        chk("first_push_cycles", 64'(n), 64'd1);
        chk("lw_out_valid", 64'(out_valid), 64'd1);
        chk("lw_ctrl", 64'(out_ctrl), 64'(15'b000_01_0_00_1_000_00_1));
        chk("lw_pc", 64'(out_pc), 64'h100);
        drain();

        // Backpressure: two entries fill the buffer, third is held off
        out_ready = 1'b0;
        push(32'h003100B3, 32'h104, 15'b000_00_0_00_0_000_10_1, 1'b0, 1'b0);
        push(32'h00312023, 32'h108, 15'b000_00_1_00_1_001_00_0, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(out_instr), 64'h003100B3);
        drive(32'h00500093, 32'h10C, 15'b000_00_0_00_1_000_11_1, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("held_in_ready", 64'(in_ready), 64'd0);
            chk("held_out_valid", 64'(out_valid), 64'd1);
            chk("held_head", 64'(out_instr), 64'h003100B3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept(n);
        drain();

        push(32'h00000013, 32'h110, 15'b000_00_0_00_1_000_11_0, 1'b0, 1'b0);
        push(32'h00000463, 32'h114, 15'b100_00_0_00_0_010_01_0, 1'b0, 1'b0);
        push(32'h010000EF, 32'h118, 15'b010_10_0_10_0_011_00_1, 1'b0, 1'b0);
        push(32'h000100E7, 32'h11C, 15'b001_10_0_00_1_000_00_1, 1'b0, 1'b0);
        push(32'h123452B7, 32'h120, 15'b000_00_0_10_1_100_00_1, 1'b0, 1'b0);
        push(32'h00000017, 32'h124, 15'b000_00_0_01_1_100_00_0, 1'b0, 1'b0);
        drain();
        chk("cnt_legal_only", 64'(illegal_cnt), 64'd0);

        repeat (3) push(32'h00000000, 32'h200, 15'b0, 1'b1, 1'b0);
        drain();
        chk("cnt_three", 64'(illegal_cnt), 64'd3);

        push(32'h00012081, 32'h204, 15'b0, 1'b1, 1'b0);
        push(32'h000110E7, 32'h208, 15'b0, 1'b1, 1'b0);
`ifdef ZICSR_DECODE_EN
        push(32'h34011073, 32'h20C, 15'b000_00_0_00_1_101_00_0, 1'b0, 1'b1);
        push(32'h00000073, 32'h210, 15'b0, 1'b0, 1'b0);
`else
        push(32'h34011073, 32'h20C, 15'b0, 1'b1, 1'b0);
`endif
        drain();
        chk("cnt_after_misc", 64'(illegal_cnt), 64'(exp_cnt));

        // Flush with a full buffer and a pending word
        out_ready = 1'b0;
        push(32'h123452B7, 32'h300, 15'b000_00_0_10_1_100_00_1, 1'b0, 1'b0);
        push(32'h00000017, 32'h304, 15'b000_00_0_01_1_100_00_0, 1'b0, 1'b0);
        drive(32'h00000000, 32'h308, 15'b0, 1'b1, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_stays_empty", 64'(out_valid), 64'd0);
        end

        // Flush coinciding with an acceptable illegal push
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(32'h003100B3, 32'h400, 15'b000_00_0_00_0_000_10_1, 1'b0, 1'b0);
        drive(32'h00000000, 32'h404, 15'b0, 1'b1, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_push_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        chk("flush_push_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a cycle
        out_ready = 1'b0;
        push(32'h00012083, 32'h500, 15'b000_01_0_00_1_000_00_1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cnt", 64'(illegal_cnt), 64'd0);
        chk("mid_rst_pc", 64'(out_pc), 64'd0);
        q.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(32'h003100B3, 32'h600, 15'b000_00_0_00_0_000_10_1, 1'b0, 1'b0);
        wait_accept(n);
        chk("post_rst_cycles", 64'(n), 64'd1);
        drain();

        // Saturation: nine illegal pushes against a 3-bit counter
        for (int i = 0; i < 9; i++) begin
            push(32'h00000000, 32'h700 + 32'(4 * i), 15'b0, 1'b1, 1'b0);
            chk("sat_step", 64'(illegal_cnt), 64'(exp_cnt));
        end
        chk("sat_all_ones", 64'(illegal_cnt), 64'd7);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ctrl_pipe.md
Name: id_ctrl_pipe

Overview:
Parametrised successor to the combinational main decoder. It decodes RV32I instructions into the 15-bit control bundle, plus illegal-instruction and rd=x0 qualification, and buffers the results in a BUF_DEPTH-entry FIFO. The FIFO has valid/ready on both sides. The block sits between the IF/ID register and the EX stage of the async pipeline and adds flush and an illegal-instruction counter.

Parameters:
XLEN, 32, width of instr/pc datapath
BUF_DEPTH, 2, FIFO entries (power of two, >=2)
CNT_W, 16, width of saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all buffered entries and the current input
in_valid  in  1  instruction/pc valid
in_ready  out  1  block can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  head entry valid
out_ready  in  1  EX accepts head
out_ctrl  out  15  {Branch,Jal,Jalr,ResultSrc[1:0],MemWrite,ALUSrcA[1:0],ALUSrcB,ImmSrc[2:0],ALUop[1:0],RegWrite}
out_illegal  out  1  head instruction illegal
out_csr  out  1  head is CSR op (0 unless feature enabled)
out_instr  out  32  head instruction
out_pc  out  XLEN  head pc
illegal_cnt  out  CNT_W  count of accepted illegal instructions, saturating

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, out_valid=0, all out_* data=0, illegal_cnt=0, pointers=0.
- Decode is combinational on in_instr. Result is stored on push and is visible at the FIFO head one cycle later (latency 1 when empty).
- Decode table, fields in out_ctrl order:
  - 0000011 LW: 0_0_0_01_0_00_1_000_00_1
  - 0100011 SW: 0_0_0_00_1_00_1_001_00_0
  - 0110011 R: 0_0_0_00_0_00_0_000_10_1
  - 1100011 B: 1_0_0_00_0_00_0_010_01_0
  - 0010011 I-ALU: 0_0_0_00_0_00_1_000_11_1
  - 1101111 JAL: 0_1_0_10_0_10_0_011_00_1
  - 1100111 JALR: 0_0_1_10_0_00_1_000_00_1
  - 0110111 LUI: 0_0_0_00_0_10_1_100_00_1
  - 0010111 AUIPC: 0_0_0_00_0_01_1_100_00_1
- Illegal when instr[1:0]!=2'b11 or the opcode is not in the table (or is the CSR opcode with the feature off). Illegal: ctrl=0, illegal=1.
- JALR additionally requires funct3=000, else illegal.
- RegWrite is forced to 0 when instr[11:7]==0 (rd=x0). All other fields are unchanged.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count < BUF_DEPTH). It is registered-state only, with no combinational path from out_ready.
- count updates: push only +1; pop only -1; push and pop together leaves count unchanged (legal whenever count < BUF_DEPTH). Pointers wrap modulo BUF_DEPTH.
- out_valid = (count != 0). Head data is held stable while out_valid & !out_ready.
- flush has priority over push and pop: next cycle count=0 and out_valid=0. A push in the flush cycle is dropped and not counted. Data registers need not clear.
- illegal_cnt increments on push of an illegal instruction when not flushing. It saturates at all-ones and never wraps.
- Reset mid-operation: immediate return to the reset state. The first push is accepted on the first clk edge with rst_n high.

Optional Feature:
ZICSR_DECODE_EN:
- Defined: opcode 1110011 decodes to 0_0_0_00_0_00_1_101_00_1 with out_csr=1. ECALL/EBREAK (funct3=000) give ctrl=0, out_csr=0, illegal=0. The rd=x0 rule still applies.
- Undefined: 1110011 is illegal, and the out_csr port is tied to 0.

Decomposition:
- Package id_ctrl_pkg: opcode localparams, the ctrl_t packed struct (15 bits in port order), and ImmSrc/ResultSrc/ALUSrcA encodings.
- Sub-module id_decode_comb: pure combinational decode of instr to {ctrl, illegal, csr}.
- The top holds the FIFO, handshake and counter.

Test Plan:
- Reset, then push LW 0x00012083 at pc 0x100 with out_ready=1 -> next cycle out_valid=1, ctrl=0_0_0_01_0_00_1_000_00_1, out_pc=0x100.
- out_ready=0, push ADD, SW, ADDI back-to-back -> in_ready drops after 2 pushes (BUF_DEPTH=2), ADDI held off. Then release out_ready -> ADD, SW, ADDI emerge in order with no loss or duplication.
- Push ADDI x0,x0,0 (0x00000013) -> RegWrite=0, ALUop=11, illegal=0.
- Push 0x00000000 three times -> illegal=1, ctrl=0 each time, illegal_cnt=3. Force the count to all-ones and push illegal again -> stays all-ones.
- FIFO full plus a pending push, assert flush for 1 cycle -> next cycle out_valid=0, in_ready=1, and the pushed word never appears.
- CSRRW 0x34011073: with ZICSR_DECODE_EN -> out_csr=1, ImmSrc=101, RegWrite=0 (rd=x0). Without it -> illegal=1, illegal_cnt increments.
